// File: rtl/average_threshold_monitor.sv
// average_threshold_monitor
// Watches the running-average stream and raises a debounced alarm with
// hysteresis: arm when the average stays above HI_THRESH for DEBOUNCE
// consecutive samples, release when it stays below LO_THRESH for DEBOUNCE
// consecutive samples. Emits one-cycle rise/fall pulses and counts rise
// events in a saturating 16-bit counter. The first WARMUP samples after
// reset are ignored while the upstream averaging window fills.
// Optional: define PEAK_TRACK_EN to add peak_o, the largest average seen
// during the current or most recent alarm episode.
module average_threshold_monitor #(
    parameter logic [31:0] HI_THRESH = 32'd200,
    parameter logic [31:0] LO_THRESH = 32'd100,
    parameter int          DEBOUNCE  = 4,
    parameter int          WARMUP    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] average_i,
    input  logic        clear_i,
    output logic        ready_o,
    output logic        alarm_o,
    output logic        rise_o,
    output logic        fall_o,
    output logic [15:0] event_count_o,
    output logic [1:0]  state_o
`ifdef PEAK_TRACK_EN
    ,
    output logic [31:0] peak_o
`endif
);

    localparam int DB_W      = $clog2(DEBOUNCE + 1);
    localparam int WU_W      = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
    localparam int WU_LAST_I = (WARMUP > 0) ? WARMUP - 1 : 0;

    localparam logic [DB_W:0]   DB_LAST = (DB_W + 1)'(DEBOUNCE);
    localparam logic [WU_W-1:0] WU_LAST = WU_W'(WU_LAST_I);

    typedef enum logic [1:0] {
        LOW       = 2'b00,
        ARMING    = 2'b01,
        ALARM     = 2'b10,
        DISARMING = 2'b11
    } state_t;

    state_t          state;
    logic [DB_W-1:0] db_cnt;
    logic [WU_W-1:0] wu_cnt;

    logic above_hi;
    logic below_lo;
    logic db_hit;
    logic enter_alarm;

    assign above_hi = (average_i > HI_THRESH);
    assign below_lo = (average_i < LO_THRESH);
    // This sample completes the run of DEBOUNCE qualifying samples.
    assign db_hit   = (({1'b0, db_cnt} + (DB_W + 1)'(1)) == DB_LAST);

    // Arming edge: the FSM leaves LOW/ARMING for ALARM at this clock edge.
    assign enter_alarm = ready_o && above_hi &&
                         (((state == LOW) && (DEBOUNCE == 1)) ||
                          ((state == ARMING) && db_hit));

    assign alarm_o = state[1];
    assign state_o = state;

    // Warm-up: count ignored samples until the upstream window is full.
    always_ff @(posedge clk) begin
        if (reset) begin
            wu_cnt  <= '0;
            ready_o <= (WARMUP == 0);
        end else if (!ready_o) begin
            wu_cnt <= wu_cnt + WU_W'(1);
            if (wu_cnt == WU_LAST) begin
                ready_o <= 1'b1;
            end
        end
    end

    // Hysteresis/debounce FSM with registered rise/fall pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= LOW;
            db_cnt <= '0;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            if (ready_o) begin
                case (state)
                    LOW: begin
                        if (above_hi) begin
                            if (DEBOUNCE == 1) begin
                                state  <= ALARM;
                                rise_o <= 1'b1;
                                db_cnt <= '0;
                            end else begin
                                state  <= ARMING;
                                db_cnt <= DB_W'(1);
                            end
                        end
                    end
                    ARMING: begin
                        if (above_hi) begin
                            if (db_hit) begin
                                state  <= ALARM;
                                rise_o <= 1'b1;
                                db_cnt <= '0;
                            end else begin
                                db_cnt <= db_cnt + DB_W'(1);
                            end
                        end else begin
                            state  <= LOW;
                            db_cnt <= '0;
                        end
                    end
                    ALARM: begin
                        // Anything at or above LO_THRESH keeps the alarm,
                        // including the band between the two thresholds.
                        if (below_lo) begin
                            if (DEBOUNCE == 1) begin
                                state  <= LOW;
                                fall_o <= 1'b1;
                                db_cnt <= '0;
                            end else begin
                                state  <= DISARMING;
                                db_cnt <= DB_W'(1);
                            end
                        end
                    end
                    DISARMING: begin
                        if (below_lo) begin
                            if (db_hit) begin
                                state  <= LOW;
                                fall_o <= 1'b1;
                                db_cnt <= '0;
                            end else begin
                                db_cnt <= db_cnt + DB_W'(1);
                            end
                        end else begin
                            // Aborted release: back to ALARM without a new rise.
                            state  <= ALARM;
                            db_cnt <= '0;
                        end
                    end
                    default: begin
                        state  <= LOW;
                        db_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // Saturating rise-event counter; clear wins over a coincident rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            event_count_o <= '0;
        end else if (clear_i) begin
            event_count_o <= '0;
        end else if (rise_o && (event_count_o != 16'hFFFF)) begin
            event_count_o <= event_count_o + 16'd1;
        end
    end

`ifdef PEAK_TRACK_EN
    // Peak tracker: load on arming edge, running max while alarmed, else hold.
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            peak_o <= '0;
        end else if (enter_alarm) begin
            peak_o <= average_i;
        end else if (state[1] && (average_i > peak_o)) begin
            peak_o <= average_i;
        end
    end
`endif

endmodule

// File: tb/tb_average_threshold_monitor.sv
// Directed testbench for average_threshold_monitor (HI=200, LO=100,
// DEBOUNCE=4, WARMUP=4). Compile with +define+PEAK_TRACK_EN to also
// exercise the peak tracker.
module tb_average_threshold_monitor;

    logic        clk;
    logic        reset;
    logic [31:0] average_i;
    logic        clear_i;
    logic        ready_o;
    logic        alarm_o;
    logic        rise_o;
    logic        fall_o;
    logic [15:0] event_count_o;
    logic [1:0]  state_o;
`ifdef PEAK_TRACK_EN
    logic [31:0] peak_o;
`endif

    int checks;
    int errors;

    average_threshold_monitor #(
        .HI_THRESH(32'd200),
        .LO_THRESH(32'd100),
        .DEBOUNCE (4),
        .WARMUP   (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .average_i    (average_i),
        .clear_i      (clear_i),
        .ready_o      (ready_o),
        .alarm_o      (alarm_o),
        .rise_o       (rise_o),
        .fall_o       (fall_o),
        .event_count_o(event_count_o),
        .state_o      (state_o)
`ifdef PEAK_TRACK_EN
        ,
        .peak_o       (peak_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flags packed as {ready, state[1:0], alarm, rise, fall}.
    function automatic logic [5:0] flags();
        return {ready_o, state_o, alarm_o, rise_o, fall_o};
    endfunction

    // Advance one clock; outputs are observed 1ns after the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        average_i = 32'd0;
        clear_i   = 1'b0;
        step(2);
        checks++;
        if (flags() !== 6'b0_00_0_0_0) begin
            errors++;
            $display("FAIL reset_flags got %b exp %b", flags(), 6'b0_00_0_0_0);
        end
        checks++;
        if (event_count_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_count got %0d exp 0", event_count_o);
        end
    endtask

    // avg=500 from cycle 0: ready at cycle 4, alarm+rise at cycle 8, count 1 at 9.
    task automatic test_arm();
        reset     = 1'b0;
        average_i = 32'd500;
        checks++;
        if (flags() !== 6'b0_00_0_0_0) begin
            errors++;
            $display("FAIL arm_c0 got %b exp %b", flags(), 6'b0_00_0_0_0);
        end
        step(3);
        checks++;
        if (flags() !== 6'b0_00_0_0_0) begin
            errors++;
            $display("FAIL arm_c3_warmup got %b exp %b", flags(), 6'b0_00_0_0_0);
        end
        step(1);
        checks++;
        if (flags() !== 6'b1_00_0_0_0) begin
            errors++;
            $display("FAIL arm_c4_ready got %b exp %b", flags(), 6'b1_00_0_0_0);
        end
        step(3);
        checks++;
        if (flags() !== 6'b1_01_0_0_0) begin
            errors++;
            $display("FAIL arm_c7_arming got %b exp %b", flags(), 6'b1_01_0_0_0);
        end
        step(1);
        checks++;
        if (flags() !== 6'b1_10_1_1_0) begin
            errors++;
            $display("FAIL arm_c8_rise got %b exp %b", flags(), 6'b1_10_1_1_0);
        end
        step(1);
        checks++;
        if ({flags(), event_count_o} !== {6'b1_10_1_0_0, 16'd1}) begin
            errors++;
            $display("FAIL arm_c9_count got %b/%0d exp %b/1", flags(), event_count_o, 6'b1_10_1_0_0);
        end
    endtask

    // Band values hold the alarm; four samples below LO release it.
    task automatic test_release();
        int held;
        average_i = 32'd150;
        held = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (flags() === 6'b1_10_1_0_0) held++;
        end
        checks++;
        if (held !== 10) begin
            errors++;
            $display("FAIL release_band_hold got %0d exp 10 cycles in ALARM", held);
        end
        average_i = 32'd50;
        step(3);
        checks++;
        if (flags() !== 6'b1_11_1_0_0) begin
            errors++;
            $display("FAIL release_disarming got %b exp %b", flags(), 6'b1_11_1_0_0);
        end
        step(1);
        checks++;
        if (flags() !== 6'b1_00_0_0_1) begin
            errors++;
            $display("FAIL release_fall got %b exp %b", flags(), 6'b1_00_0_0_1);
        end
        step(1);
        checks++;
        if ({flags(), event_count_o} !== {6'b1_00_0_0_0, 16'd1}) begin
            errors++;
            $display("FAIL release_after got %b/%0d exp %b/1", flags(), event_count_o, 6'b1_00_0_0_0);
        end
    endtask

    // Three highs then a band value: ARMING aborts back to LOW.
    task automatic test_arm_abort();
        average_i = 32'd250;
        step(3);
        checks++;
        if (flags() !== 6'b1_01_0_0_0) begin
            errors++;
            $display("FAIL abort_arming got %b exp %b", flags(), 6'b1_01_0_0_0);
        end
        average_i = 32'd150;
        step(1);
        checks++;
        if ({flags(), event_count_o} !== {6'b1_00_0_0_0, 16'd1}) begin
            errors++;
            $display("FAIL abort_low got %b/%0d exp %b/1", flags(), event_count_o, 6'b1_00_0_0_0);
        end
    endtask

    // 50,50,120 in ALARM: back to ALARM with no rise, count unchanged.
    task automatic test_disarm_abort();
        average_i = 32'd300;
        step(4);
        checks++;
        if (flags() !== 6'b1_10_1_1_0) begin
            errors++;
            $display("FAIL rearm_rise got %b exp %b", flags(), 6'b1_10_1_1_0);
        end
        average_i = 32'd50;
        step(2);
        checks++;
        if (flags() !== 6'b1_11_1_0_0) begin
            errors++;
            $display("FAIL disarm_state got %b exp %b", flags(), 6'b1_11_1_0_0);
        end
        average_i = 32'd120;
        step(1);
        checks++;
        if ({flags(), event_count_o} !== {6'b1_10_1_0_0, 16'd2}) begin
            errors++;
            $display("FAIL disarm_abort got %b/%0d exp %b/2", flags(), event_count_o, 6'b1_10_1_0_0);
        end
        average_i = 32'd50;
        step(4);
        checks++;
        if (flags() !== 6'b1_00_0_0_1) begin
            errors++;
            $display("FAIL disarm_release got %b exp %b", flags(), 6'b1_00_0_0_1);
        end
    endtask

    // clear_i in the rise_o cycle beats the increment.
    task automatic test_clear_on_rise();
        average_i = 32'd300;
        step(4);
        checks++;
        if ({flags(), event_count_o} !== {6'b1_10_1_1_0, 16'd2}) begin
            errors++;
            $display("FAIL clear_rise got %b/%0d exp %b/2", flags(), event_count_o, 6'b1_10_1_1_0);
        end
        clear_i = 1'b1;
        step(1);
        clear_i = 1'b0;
        checks++;
        if ({flags(), event_count_o} !== {6'b1_10_1_0_0, 16'd0}) begin
            errors++;
            $display("FAIL clear_priority got %b/%0d exp %b/0", flags(), event_count_o, 6'b1_10_1_0_0);
        end
        step(1);
        checks++;
        if (event_count_o !== 16'd0) begin
            errors++;
            $display("FAIL clear_hold got %0d exp 0", event_count_o);
        end
    endtask

    // Reset while DISARMING: everything zero, no fall, warm-up restarts.
    task automatic test_reset_mid();
        average_i = 32'd50;
        step(2);
        checks++;
        if (flags() !== 6'b1_11_1_0_0) begin
            errors++;
            $display("FAIL mid_disarming got %b exp %b", flags(), 6'b1_11_1_0_0);
        end
        reset = 1'b1;
        step(1);
        checks++;
        if ({flags(), event_count_o} !== {6'b0_00_0_0_0, 16'd0}) begin
            errors++;
            $display("FAIL mid_reset got %b/%0d exp %b/0", flags(), event_count_o, 6'b0_00_0_0_0);
        end
        reset = 1'b0;
        step(3);
        checks++;
        if (flags() !== 6'b0_00_0_0_0) begin
            errors++;
            $display("FAIL mid_warmup got %b exp %b", flags(), 6'b0_00_0_0_0);
        end
        step(1);
        checks++;
        if (flags() !== 6'b1_00_0_0_0) begin
            errors++;
            $display("FAIL mid_ready got %b exp %b", flags(), 6'b1_00_0_0_0);
        end
    endtask

`ifdef PEAK_TRACK_EN
    task automatic test_peak();
        checks++;
        if (peak_o !== 32'd0) begin
            errors++;
            $display("FAIL peak_reset got %0d exp 0", peak_o);
        end
        average_i = 32'd300;
        step(4);
        checks++;
        if (peak_o !== 32'd300) begin
            errors++;
            $display("FAIL peak_load got %0d exp 300", peak_o);
        end
        average_i = 32'd450;
        step(1);
        average_i = 32'd320;
        step(1);
        checks++;
        if (peak_o !== 32'd450) begin
            errors++;
            $display("FAIL peak_max got %0d exp 450", peak_o);
        end
        average_i = 32'd50;
        step(5);
        average_i = 32'd500;
        step(1);
        checks++;
        if ({state_o, peak_o} !== {2'b01, 32'd450}) begin
            errors++;
            $display("FAIL peak_hold got %b/%0d exp 01/450", state_o, peak_o);
        end
        average_i = 32'd50;
        clear_i   = 1'b1;
        step(1);
        clear_i   = 1'b0;
        checks++;
        if (peak_o !== 32'd0) begin
            errors++;
            $display("FAIL peak_clear got %0d exp 0", peak_o);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_arm();
        test_release();
        test_arm_abort();
        test_disarm_abort();
        test_clear_on_rise();
        test_reset_mid();
`ifdef PEAK_TRACK_EN
        test_peak();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
